// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - 4-digit 7-segment scan driver feeding a 2x4 digit-select decoder
// Snapshots value/dp_mask/lz_blank once per frame; each digit slot opens with a blanking gap.
module fnd_scan_ctrl #(
   parameter int CLK_DIV   = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [15:0] value,
   input  logic [3:0]  dp_mask,
   input  logic        lz_blank,
   output logic [1:0]  sel,
   output logic        sel_en,
   output logic [7:0]  seg,
   output logic        frame_done
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_BLEND = CW'(BLANK_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_sel;
   logic            r_sel_en;
   logic [7:0]      r_seg;
   logic            r_frame_done;
   logic [15:0]     r_snap_val;
   logic [3:0]      r_snap_dp;
   logic            r_snap_lz;

   state_t          w_state_nx;
   logic [CW-1:0]   w_cnt_nx;
   logic [1:0]      w_sel_nx;
   logic            w_sel_en_nx;
   logic [7:0]      w_seg_nx;
   logic            w_frame_done_nx;
   logic            w_load;
   logic [3:0]      w_nib;
   logic            w_lz_hit;
   logic [7:0]      w_glyph;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   assign w_nib = r_snap_val[{r_sel, 2'b00} +: 4];

   // A digit is a leading zero only if it and every more-significant nibble are zero.
   always_comb begin
      w_lz_hit = 1'b0;
      case (r_sel)
         2'd3:    w_lz_hit = (r_snap_val[15:12] == 4'h0);
         2'd2:    w_lz_hit = (r_snap_val[15:8] == 8'h00);
         2'd1:    w_lz_hit = (r_snap_val[15:4] == 12'h000);
         default: w_lz_hit = 1'b0;
      endcase
   end

   assign w_glyph = {~r_snap_dp[r_sel], (r_snap_lz && w_lz_hit) ? 7'h7F : hex7(w_nib)};

   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_sel_nx    = r_sel;
      w_sel_en_nx = 1'b0;
      w_seg_nx    = 8'hFF;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (run) begin
               w_state_nx = ST_BLANK;
               w_cnt_nx   = '0;
               w_sel_nx   = 2'd0;
               w_load     = 1'b1;
            end
         end
         ST_BLANK: begin
            w_cnt_nx = r_cnt + CW'(1);
            if (r_cnt == CNT_BLEND) begin
               w_state_nx  = ST_DRIVE;
               w_sel_en_nx = 1'b1;
               w_seg_nx    = w_glyph;
            end
         end
         ST_DRIVE: begin
            w_sel_en_nx = 1'b1;
            w_seg_nx    = r_seg;
            if (r_cnt == CNT_LAST) begin
               w_cnt_nx    = '0;
               w_state_nx  = ST_BLANK;
               w_sel_nx    = r_sel + 2'd1;
               w_sel_en_nx = 1'b0;
               w_seg_nx    = 8'hFF;
               w_load      = (r_sel == 2'd3);
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
      if (!run) begin
         w_state_nx  = ST_IDLE;
         w_cnt_nx    = '0;
         w_sel_nx    = 2'd0;
         w_sel_en_nx = 1'b0;
         w_seg_nx    = 8'hFF;
         w_load      = 1'b0;
      end
   end

   // Registered so the pulse lands on the last DRIVE cycle of digit 3.
   assign w_frame_done_nx = (w_state_nx == ST_DRIVE) && (w_cnt_nx == CNT_LAST) && (w_sel_nx == 2'd3);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_sel        <= 2'd0;
         r_sel_en     <= 1'b0;
         r_seg        <= 8'hFF;
         r_frame_done <= 1'b0;
         r_snap_val   <= 16'h0000;
         r_snap_dp    <= 4'h0;
         r_snap_lz    <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_cnt        <= w_cnt_nx;
         r_sel        <= w_sel_nx;
         r_sel_en     <= w_sel_en_nx;
         r_seg        <= w_seg_nx;
         r_frame_done <= w_frame_done_nx;
         if (w_load) begin
            r_snap_val <= value;
            r_snap_dp  <= dp_mask;
            r_snap_lz  <= lz_blank;
         end
      end
   end

   assign sel        = r_sel;
   assign sel_en     = r_sel_en;
   assign seg        = r_seg;
   assign frame_done = r_frame_done;

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
- Time-multiplexed driver for a 4-digit common-anode 7-segment display (FND).
- Sits directly upstream of the 2x4 active-low digit-select decoder. It produces that decoder's 2-bit select and enable, plus the segment pattern for the currently selected digit.
- Snapshots a 16-bit hex/BCD value once per frame.
- Inserts a blanking gap between digits to suppress ghosting, and supports leading-zero blanking and per-digit decimal points.

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot, including the blank portion; must be > BLANK_CYC.
- BLANK_CYC, 16: cycles at the start of each slot with sel_en = 0; must be >= 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  scan enable; 0 forces the idle state.
- value  input  16  four nibbles; digit k = value[4k+3:4k]; digit 0 is least significant (rightmost).
- dp_mask  input  4  bit k = 1 lights the decimal point of digit k.
- lz_blank  input  1  1 enables leading-zero blanking.
- sel  output  2  digit index; feeds the decoder's 2-bit input.
- sel_en  output  1  feeds the decoder's enable input.
- seg  output  8  {dp,g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse on the last cycle of the digit-3 slot.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - sel = 0, sel_en = 0, seg = 8'hFF, frame_done = 0.
  - State = IDLE; slot counter = 0; snapshot register = 0.
  - rst overrides run.
- Register rules:
  - All outputs are registered; there is no combinational path from inputs to outputs.
  - Slot counter width is $clog2(CLK_DIV).
- State machine:
  - States: IDLE, BLANK, DRIVE.
- IDLE:
  - Outputs are held at their reset values.
  - When run = 1, the next edge loads snapshot = value, sets sel = 0, cnt = 0, and enters BLANK.
- BLANK:
  - sel_en = 0, seg = 8'hFF, cnt increments.
  - When cnt = BLANK_CYC-1, the next edge enters DRIVE.
  - On that same edge, sel_en = 1 and seg = the glyph for digit sel.
- DRIVE:
  - sel_en = 1, seg is held, cnt increments.
  - When cnt = CLK_DIV-1, the next edge sets cnt = 0 and enters BLANK with sel = sel+1, wrapping 3 -> 0.
  - When wrapping to 0, the same edge reloads snapshot = value.
- frame_done:
  - Asserts for exactly the one cycle in which sel = 3 and cnt = CLK_DIV-1 (DRIVE state).
- Value sampling:
  - value is sampled only at frame start.
  - Mid-frame changes never alter the digits of the current frame (no tearing).
  - lz_blank and dp_mask are sampled together with value into the snapshot.
- sel timing:
  - sel changes only on the edge entering BLANK, so sel never changes while sel_en = 1.
- Glyphs (active-low, dp bit excluded):
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
  - seg[7] = ~dp_mask[sel].
- Leading-zero blanking (lz_blank = 1):
  - Digit k (k >= 1) shows 8'hFF (dp still applied) when its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked, so value 0 shows "0".
  - sel_en timing is unchanged by blanking.
- run deasserted in any state:
  - The next edge enters IDLE with reset-value outputs; frame_done stays 0.
  - On the next run = 1, the frame restarts at digit 0 with a fresh snapshot.
- Frame length: 4*CLK_DIV cycles.
- Duty: sel_en is high (CLK_DIV-BLANK_CYC)/CLK_DIV of each slot.

Test Plan:
- Reset check (all bench cases use CLK_DIV=8, BLANK_CYC=2):
  - Stimulus: rst = 1 for 3 cycles with run = 1.
  - Required: sel = 0, sel_en = 0, seg = FF, frame_done = 0 throughout; scanning starts only after rst falls.
- Basic scan:
  - Stimulus: value = 16'h1234, run rises; cycle 0 is the first BLANK cycle.
  - Cycles 0-1: sel = 0, sel_en = 0, seg = FF.
  - Cycles 2-7: sel_en = 1, seg = 99.
  - Slots 1/2/3: seg = B0 / A4 / F9 with sel = 1/2/3.
  - frame_done high only at cycle 31.
  - Cycle 32: sel = 0, sel_en = 0.
- Snapshot:
  - Stimulus: change value to 16'h9999 at cycle 10.
  - Required: digits 1-3 of the current frame still show B0, A4, F9; the next frame shows 90 on all digits.
- Leading-zero blanking:
  - lz_blank = 1, value = 16'h0050: digits 3 and 2 show seg = FF with sel_en still pulsing; digit 1 = 92; digit 0 = C0.
  - value = 0: digit 0 = C0; others FF.
  - value = 16'h0500: digit 1 = C0 (not blanked).
- Decimal point:
  - dp_mask = 4'b0010, value = 16'h0050, lz_blank = 0.
  - Required: digit 1 seg = 12; other digits have bit7 = 1 (digit 3 = C0).
- Abort mid-frame:
  - run falls at cycle 13: next edge sel_en = 0, seg = FF, sel = 0, no frame_done.
  - run re-raised with value = 16'hABCD: restart at digit 0 with seg = A1 in its DRIVE window.
  - rst at cycle 20 behaves identically.
